// File: rtl/demux8_pkg.sv
// Shared definitions for the 1-to-8 round-robin dispatcher.
//   state_e  : dispatcher state (IDLE = buffer empty, HOLD = word presented)
//   NCH, SW  : channel count and select width
//   onehot8  : 3-bit select to one-hot channel mask
package demux8_pkg;

    localparam int NCH = 8;
    localparam int SW  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    function automatic logic [NCH-1:0] onehot8(input logic [SW-1:0] sel);
        return 8'b0000_0001 << sel;
    endfunction

endpackage

// File: rtl/demux8_rr_dispatcher_rr_pick8.sv
// rr_pick8: combinational wrap-around priority search.
//   base  [2:0] in  : first position to consider
//   mask  [7:0] in  : candidate bits
//   idx   [2:0] out : first set mask bit at or after base (mod 8)
//   found       out : any mask bit set
module rr_pick8
    import demux8_pkg::*;
(
    input  logic [SW-1:0]  base,
    input  logic [NCH-1:0] mask,
    output logic [SW-1:0]  idx,
    output logic           found
);

    logic [SW-1:0] cand;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < NCH; i++) begin
            // 3-bit add wraps 7 -> 0 naturally
            cand = base + SW'(i);
            if (!found && mask[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux8_rr_dispatcher.sv
// demux8_rr_dispatcher: one-word buffer routing a valid/ready stream to
// 8 consumers, round-robin over the enabled channels.
//   clk, rst              : clock, synchronous active-high reset
//   in_data/valid/ready   : producer stream
//   chan_en[7:0]          : channel enable mask (only used when picking)
//   out_data              : held word, shared by all channels
//   out_valid[7:0]        : one-hot valid for the held word's channel
//   out_ready[7:0]        : per-channel consumer ready
//   s[2:0]                : destination of the held word
//   busy                  : buffer holds a word
// Optional (DEMUX8_RR_STATS_EN): fire_cnt[15:0] fire counter, stall flag.
module demux8_rr_dispatcher #(
    parameter int DW  = 8,
    parameter int NCH = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [DW-1:0]  in_data,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [NCH-1:0] chan_en,
    output logic [DW-1:0]  out_data,
    output logic [NCH-1:0] out_valid,
    input  logic [NCH-1:0] out_ready,
    output logic [2:0]     s,
    output logic           busy
`ifdef DEMUX8_RR_STATS_EN
    ,
    output logic [15:0]    fire_cnt,
    output logic           stall
`endif
);

    import demux8_pkg::*;

    state_e        state_q, state_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [2:0]    s_q, s_d;
    logic [DW-1:0] data_q, data_d;

    logic          fire, accept;
    logic [2:0]    base, pick_idx;
    logic          pick_found;

    assign busy = (state_q == HOLD);
    assign fire = busy & out_ready[s_q];

    // Searching past the outgoing word when it leaves this cycle keeps
    // back-to-back traffic rotating instead of reusing the stale ptr.
    assign base = fire ? (s_q + 3'd1) : ptr_q;

    rr_pick8 u_pick (
        .base  (base),
        .mask  (chan_en),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // pick_found == |chan_en: nothing is accepted with no channel enabled
    assign in_ready = pick_found & (~busy | fire);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        s_d     = s_q;
        data_d  = data_q;
        if (fire) begin
            ptr_d = s_q + 3'd1;
        end
        if (accept) begin
            state_d = HOLD;
            s_d     = pick_idx;
            data_d  = in_data;
        end else if (fire) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            s_q     <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            s_q     <= s_d;
            data_q  <= data_d;
        end
    end

    assign out_data  = data_q;
    assign s         = s_q;
    assign out_valid = busy ? onehot8(s_q) : '0;

`ifdef DEMUX8_RR_STATS_EN
    logic [15:0] fire_cnt_q, fire_cnt_d;

    always_comb begin
        fire_cnt_d = fire_cnt_q;
        if (fire) begin
            fire_cnt_d = fire_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fire_cnt_q <= '0;
        end else begin
            fire_cnt_q <= fire_cnt_d;
        end
    end

    assign fire_cnt = fire_cnt_q;
    assign stall    = busy & ~out_ready[s_q];
`endif

endmodule

// File: tb/tb_demux8_rr_dispatcher.sv
// Scoreboard bench for demux8_rr_dispatcher: the driver pushes the expected
// destination/data/latency on every accept, a monitor pops on every fire.
module tb_demux8_rr_dispatcher;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] chan_en;
    logic [7:0] out_data;
    logic [7:0] out_valid;
    logic [7:0] out_ready;
    logic [2:0] s;
    logic       busy;
`ifdef DEMUX8_RR_STATS_EN
    logic [15:0] fire_cnt;
    logic        stall;
`endif

    demux8_rr_dispatcher #(.DW(8), .NCH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .chan_en   (chan_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .busy      (busy)
`ifdef DEMUX8_RR_STATS_EN
        ,
        .fire_cnt  (fire_cnt),
        .stall     (stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         dest;
        int         lat;
        int         acc_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   fires_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: every fire must match the oldest outstanding accept.
    always @(negedge clk) begin
        if (!rst && busy && out_ready[s]) begin
            fires_seen++;
            if (exp_q.size() == 0) begin
                chk("unexpected_fire", {24'd0, out_data}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_valid", {24'd0, out_valid}, 32'(8'b1 << e.dest));
                chk("s",         {29'd0, s},         32'(e.dest));
                chk("out_data",  {24'd0, out_data},  {24'd0, e.data});
                chk("latency",   32'(cyc - e.acc_cyc), 32'(e.lat));
            end
        end
    end

    // Present one word; accepted at the first negedge showing in_ready.
    task automatic send(input logic [7:0] d, input int dest, input int lat, input bit nowait);
        int waited;
        exp_t e;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 50) begin
                chk("accept_timeout", 32'(waited), 32'd0);
                in_valid = 1'b0;
                return;
            end
        end
        e.data = d; e.dest = dest; e.lat = lat; e.acc_cyc = cyc;
        exp_q.push_back(e);
        if (nowait) chk("in_ready_nowait", 32'(waited), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    logic [7:0] t2_dest [6] = '{8'd2, 8'd5, 8'd7, 8'd2, 8'd5, 8'd7};

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        chan_en = 8'h00; out_ready = 8'hFF;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {24'd0, out_valid}, 32'd0);
        chk("rst_s",         {29'd0, s},         32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_out_data",  {24'd0, out_data},  32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
        @(posedge clk); #1;

        // 1: full throughput over all channels
        chan_en = 8'hFF; out_ready = 8'hFF;
        for (int i = 0; i < 10; i++) send(8'h10 + 8'(i), i % 8, 1, 1'b1);
        idle(2);

        // 2: sparse enables 2,5,7 (ptr = 2 after test 1)
        chan_en = 8'b1010_0100;
        for (int i = 0; i < 6; i++) send(8'hA0 + 8'(i), int'(t2_dest[i]), 1, 1'b1);
        idle(2);

        // 3: stall on channel 3 for 5 cycles (other readies high)
        chan_en = 8'h88; out_ready = 8'hF7;
        send(8'h55, 3, 6, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_out_valid", {24'd0, out_valid}, 32'h08);
            chk("stall_out_data",  {24'd0, out_data},  32'h55);
            chk("stall_in_ready",  {31'd0, in_ready},  32'd0);
`ifdef DEMUX8_RR_STATS_EN
            chk("stall_flag", {31'd0, stall}, 32'd1);
`endif
        end
        @(posedge clk); #1;
        out_ready = 8'hFF;
        send(8'h66, 7, 1, 1'b1);
        idle(2);

        // 4: no channel enabled blocks the producer
        chan_en = 8'h00; in_valid = 1'b1; in_data = 8'h44;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("noen_in_ready",  {31'd0, in_ready},  32'd0);
            chk("noen_out_valid", {24'd0, out_valid}, 32'd0);
        end
        @(posedge clk); #1;
        chan_en = 8'h10;
        send(8'h44, 4, 1, 1'b1);
        idle(2);

        // 5: reset while holding on channel 6; the held word is dropped
        chan_en = 8'h40; out_ready = 8'h00;
        in_valid = 1'b1; in_data = 8'h77;
        @(negedge clk);
        chk("pre_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("hold6_out_valid", {24'd0, out_valid}, 32'h40);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_out_valid", {24'd0, out_valid}, 32'd0);
        chk("post_rst_s",         {29'd0, s},         32'd0);
        chk("post_rst_busy",      {31'd0, busy},      32'd0);
        fires_seen = 0;
        @(posedge clk); #1;
        chan_en = 8'hFF; out_ready = 8'hFF;
        send(8'h88, 0, 1, 1'b1);

        // 6: 19 more words -> 20 fires since reset
        for (int i = 0; i < 19; i++) send(8'hC0 + 8'(i), (i + 1) % 8, 1, 1'b1);
        idle(3);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("fires_since_rst", 32'(fires_seen), 32'd20);
`ifdef DEMUX8_RR_STATS_EN
        chk("fire_cnt", {16'd0, fire_cnt}, 32'd20);
        chk("stall_idle", {31'd0, stall}, 32'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
